// File: rtl/test_hu_moment_acc.sv
// test_hu_moment_acc
// Frame-level accumulator for the Hu-moment datapath. Sums 24-bit unsigned
// products over one frame (terminated by s_last) and hands the sum, the beat
// count and an overflow flag to the Hu-invariant stage via a registered
// valid/ready port. While a result is pending the input is stalled.
//
// Build option: define TEST_HU_ACC_SAT_EN to saturate the accumulator and the
// beat counter at all-ones instead of wrapping. m_ovf flags either event in
// both builds; the port list does not change.
module test_hu_moment_acc #(
  parameter int DIN_WIDTH = 24,
  parameter int ACC_WIDTH = 48,
  parameter int CNT_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ce,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DIN_WIDTH-1:0] s_data,
  input  logic                 s_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [ACC_WIDTH-1:0] m_sum,
  output logic [CNT_WIDTH-1:0] m_count,
  output logic                 m_ovf
);

  typedef enum logic [0:0] {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;

  logic [ACC_WIDTH-1:0] acc_r;
  logic [CNT_WIDTH-1:0] cnt_r;
  logic                 ovf_r;

  logic [ACC_WIDTH-1:0] m_sum_r;
  logic [CNT_WIDTH-1:0] m_count_r;
  logic                 m_ovf_r;
  logic                 m_valid_r;

  logic [ACC_WIDTH:0]   sum_ext_s;
  logic [CNT_WIDTH:0]   cnt_ext_s;
  logic [ACC_WIDTH-1:0] acc_new_s;
  logic [CNT_WIDTH-1:0] cnt_new_s;
  logic                 beat_ovf_s;
  logic                 in_xfer_s;
  logic                 out_xfer_s;

  // One extra bit on each adder exposes the carry that marks overflow.
  assign sum_ext_s  = {1'b0, acc_r} + {{(ACC_WIDTH + 1 - DIN_WIDTH){1'b0}}, s_data};
  assign cnt_ext_s  = {1'b0, cnt_r} + {{CNT_WIDTH{1'b0}}, 1'b1};
  assign beat_ovf_s = sum_ext_s[ACC_WIDTH] | cnt_ext_s[CNT_WIDTH];

  // Input is accepted only while accumulating; result leaves only while held.
  assign s_ready    = (state_r == ST_ACC);
  assign in_xfer_s  = ce & s_valid & s_ready;
  assign out_xfer_s = ce & m_valid_r & m_ready;

  assign m_valid = m_valid_r;
  assign m_sum   = m_sum_r;
  assign m_count = m_count_r;
  assign m_ovf   = m_ovf_r;

  // Next accumulator/counter value for this beat: wrap or clamp on carry.
  always_comb begin
    acc_new_s = sum_ext_s[ACC_WIDTH-1:0];
    cnt_new_s = cnt_ext_s[CNT_WIDTH-1:0];
`ifdef TEST_HU_ACC_SAT_EN
    acc_new_s = sum_ext_s[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum_ext_s[ACC_WIDTH-1:0];
    cnt_new_s = cnt_ext_s[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : cnt_ext_s[CNT_WIDTH-1:0];
`else
    acc_new_s = sum_ext_s[ACC_WIDTH-1:0];
    cnt_new_s = cnt_ext_s[CNT_WIDTH-1:0];
`endif
  end

  // Next-state logic: leave ACC on the last beat, leave HOLD on result handoff.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_ACC: begin
        if (in_xfer_s && s_last) begin
          state_nxt_s = ST_HOLD;
        end else begin
          state_nxt_s = ST_ACC;
        end
      end
      ST_HOLD: begin
        if (out_xfer_s) begin
          state_nxt_s = ST_ACC;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: state_nxt_s = ST_ACC;
    endcase
  end

  // State register; ce low freezes the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_ACC;
    end else if (ce) begin
      state_r <= state_nxt_s;
    end
  end

  // Running frame sum, beat count and sticky overflow; cleared at frame end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_r <= {ACC_WIDTH{1'b0}};
      cnt_r <= {CNT_WIDTH{1'b0}};
      ovf_r <= 1'b0;
    end else if (in_xfer_s) begin
      if (s_last) begin
        acc_r <= {ACC_WIDTH{1'b0}};
        cnt_r <= {CNT_WIDTH{1'b0}};
        ovf_r <= 1'b0;
      end else begin
        acc_r <= acc_new_s;
        cnt_r <= cnt_new_s;
        ovf_r <= ovf_r | beat_ovf_s;
      end
    end
  end

  // Result registers: captured on the last beat, held until handed off.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid_r <= 1'b0;
      m_sum_r   <= {ACC_WIDTH{1'b0}};
      m_count_r <= {CNT_WIDTH{1'b0}};
      m_ovf_r   <= 1'b0;
    end else if (in_xfer_s && s_last) begin
      m_valid_r <= 1'b1;
      m_sum_r   <= acc_new_s;
      m_count_r <= cnt_new_s;
      m_ovf_r   <= ovf_r | beat_ovf_s;
    end else if (out_xfer_s) begin
      m_valid_r <= 1'b0;
    end
  end

endmodule
